// File: rtl/serial_demux7.sv
// Purpose: receive end of the select-mux serial link; steers beat k into slot k of a WIDTH-bit frame.
// Latency: out_data/out_valid update 1 clock after the last accepted beat (data or parity beat).
// Backpressure: none; in_valid=0 cycles are stalls that hold all state, and there is no timeout.
//
// Ports:
//   clock        rising-edge system clock
//   reset        synchronous, active-high; discards any partial frame
//   in_bit       serial data bit, qualified by in_valid
//   in_valid     in_bit carries a beat this cycle
//   frame_start  marks the slot-0 beat (only meaningful with in_valid)
//   out_data     last complete frame, bit k = slot k; holds until next completion/reset
//   out_valid    one-cycle pulse when out_data has just been updated
//   busy         a frame is in progress (COLLECT or PARITY)
//   err          one-cycle pulse on an aborted frame or a parity failure
//
// Optional feature: define SERIAL_DEMUX_PARITY_EN to expect one even-parity
// beat after slot WIDTH-1 (XOR of data bits and parity bit must be 0).
module serial_demux7 #(
  parameter int WIDTH = 7,  // slots per frame, 2..8
  parameter int CW    = 3   // slot-counter width, 2**CW >= WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1
`ifdef SERIAL_DEMUX_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  localparam logic [CW-1:0] LAST_SLOT = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic             out_valid_nxt;
  logic             err_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shadow    <= shadow_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    shadow_nxt    = shadow;
    out_data_nxt  = out_data;
    out_valid_nxt = 1'b0;
    err_nxt       = 1'b0;

    if (in_valid) begin
      case (state)
        IDLE: begin
          // Beats without frame_start are silently dropped until a frame begins.
          if (frame_start) begin
            shadow_nxt[0] = in_bit;
            cnt_nxt       = CW'(1);
            state_nxt     = COLLECT;
          end
        end

        COLLECT: begin
          if (frame_start) begin
            // A new slot-0 beat mid-frame restarts collection; the previous
            // partial frame never reaches out_data.
            err_nxt       = 1'b1;
            shadow_nxt[0] = in_bit;
            cnt_nxt       = CW'(1);
          end else begin
            shadow_nxt[cnt] = in_bit;
            if (cnt == LAST_SLOT) begin
              cnt_nxt = '0;
`ifdef SERIAL_DEMUX_PARITY_EN
              state_nxt = PARITY;
`else
              // Final bit is merged straight into the published word.
              out_data_nxt  = shadow_nxt;
              out_valid_nxt = 1'b1;
              state_nxt     = IDLE;
`endif
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end

`ifdef SERIAL_DEMUX_PARITY_EN
        PARITY: begin
          if (frame_start) begin
            err_nxt       = 1'b1;
            shadow_nxt[0] = in_bit;
            cnt_nxt       = CW'(1);
            state_nxt     = COLLECT;
          end else begin
            state_nxt = IDLE;
            if ((^shadow ^ in_bit) == 1'b0) begin
              out_data_nxt  = shadow;
              out_valid_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
`endif

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
